key_input: RTL and testbench

- Upstream input-conditioning stage for the game FSM.
- Takes the raw, active-low, asynchronous KEY buttons and synchronises and debounces each one.
- Produces:
  - Debounced levels.
  - Single-cycle press pulses.
  - Per-frame press snapshots. These let the game FSM see at most one press per key per frame, aligned to the frame pulse.
- Sits between the board pins and the game state machine, on the same clk and frame strobe.

---
 rtl/key_input_pkg.sv | 16 +
 rtl/debounce_bit.sv | 63 ++++++
 rtl/key_input.sv | 109 ++++++++++
 tb/tb_key_input.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_input_pkg.sv
// Shared constants and helpers for the key_input conditioning stage.
package key_input_pkg;

    localparam int N_KEYS              = 4;
    localparam int DEBOUNCE_CYCLES     = 500000;   // 10 ms at 50 MHz
    localparam int CNT_W               = 19;
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam bit KEY_ACTIVE_LOW      = 1'b1;
    localparam int REPEAT_DELAY_FRAMES = 30;
    localparam int REPEAT_RATE_FRAMES  = 6;

    function automatic logic to_active_high(input logic raw);
        return KEY_ACTIVE_LOW ? ~raw : raw;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One key: two-flop synchroniser, stable-count debounce and registered edge pulses.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    import key_input_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q, release_q;
    logic             sync_act;

    assign sync_act = to_active_high(sync_q[1]);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_act == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_act;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= {2{KEY_ACTIVE_LOW}};   // synchroniser parked at "released"
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_raw_i};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            release_q   <= ~level_q & level_dly_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_input.sv
// Key conditioning top: per-key debounce plus per-frame press snapshots.
// Optional auto-repeat into the frame snapshot is enabled with `define KEY_REPEAT_EN.
module key_input #(
    parameter int N_KEYS          = key_input_pkg::N_KEYS,
    parameter int DEBOUNCE_CYCLES = key_input_pkg::DEBOUNCE_CYCLES,
    parameter int CNT_W           = key_input_pkg::CNT_W
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY_FRAMES = key_input_pkg::REPEAT_DELAY_FRAMES,
    parameter int REPEAT_RATE_FRAMES  = key_input_pkg::REPEAT_RATE_FRAMES
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_frame_press
);
    logic [N_KEYS-1:0] accum_q, accum_d;
    logic [N_KEYS-1:0] snap_q, snap_d;
    logic [N_KEYS-1:0] rep_fire;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .key_raw_i(KEY[i]),
            .level_o  (key_level[i]),
            .press_o  (key_press[i]),
            .release_o(key_release[i])
        );

`ifdef KEY_REPEAT_EN
        localparam int HELD_W = $clog2(REPEAT_DELAY_FRAMES + 2);
        localparam int RATE_W = $clog2(REPEAT_RATE_FRAMES) + 1;

        logic [HELD_W-1:0] held_q, held_d;
        logic [RATE_W-1:0] rate_q, rate_d;
        logic              fire;

        // held_q saturates; rate_q keeps the cadence going once held_q is pinned.
        always_comb begin
            held_d = held_q;
            rate_d = rate_q;
            fire   = 1'b0;
            if (!key_level[i]) begin
                held_d = '0;
                rate_d = '0;
            end else if (frame) begin
                if (held_q != '1) held_d = held_q + 1'b1;
                if (held_d == HELD_W'(REPEAT_DELAY_FRAMES)) begin
                    fire   = 1'b1;
                    rate_d = '0;
                end else if (held_d > HELD_W'(REPEAT_DELAY_FRAMES)) begin
                    if (rate_q == RATE_W'(REPEAT_RATE_FRAMES - 1)) begin
                        fire   = 1'b1;
                        rate_d = '0;
                    end else begin
                        rate_d = rate_q + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                held_q <= '0;
                rate_q <= '0;
            end else begin
                held_q <= held_d;
                rate_q <= rate_d;
            end
        end

        assign rep_fire[i] = fire;
`else
        assign rep_fire[i] = 1'b0;
`endif
    end

    // A press coinciding with frame lands in the new snapshot and is not carried over.
    always_comb begin
        snap_d  = snap_q;
        accum_d = accum_q | key_press;
        if (frame) begin
            snap_d  = accum_q | key_press | rep_fire;
            accum_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accum_q <= '0;
            snap_q  <= '0;
        end else begin
            accum_q <= accum_d;
            snap_q  <= snap_d;
        end
    end

    assign key_frame_press = snap_q;

endmodule

// File: tb/tb_key_input.sv
// Directed bench for key_input with a 4-cycle debounce.
module tb_key_input;
    import key_input_pkg::*;

    localparam int NK = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame;
    logic [NK-1:0] KEY;
    logic [NK-1:0] key_level, key_press, key_release, key_frame_press;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_input #(
        .N_KEYS         (NK),
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
        .CNT_W          (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame          (frame),
        .KEY            (KEY),
        .key_level      (key_level),
        .key_press      (key_press),
        .key_release    (key_release),
        .key_frame_press(key_frame_press)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        step(1);
        frame = 1'b0;
    endtask

    task automatic test_reset();
        logic [NK-1:0] exp_level, exp_press;
        rst = 1'b1; KEY = 4'b0000; frame = 1'b0;
        step(3);
        n_checks++;
        if (key_level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %b expected 0000", key_level); end
        n_checks++;
        if (key_press !== 4'b0000) begin n_fail++; $display("FAIL reset_press: got %b expected 0000", key_press); end
        n_checks++;
        if (key_release !== 4'b0000) begin n_fail++; $display("FAIL reset_release: got %b expected 0000", key_release); end
        n_checks++;
        if (key_frame_press !== 4'b0000) begin n_fail++; $display("FAIL reset_frame_press: got %b expected 0000", key_frame_press); end
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            exp_level = (c >= 6) ? 4'b1111 : 4'b0000;
            exp_press = (c == 7) ? 4'b1111 : 4'b0000;
            n_checks++;
            if (key_level !== exp_level) begin n_fail++; $display("FAIL post_reset_level c=%0d: got %b expected %b", c, key_level, exp_level); end
            n_checks++;
            if (key_press !== exp_press) begin n_fail++; $display("FAIL post_reset_press c=%0d: got %b expected %b", c, key_press, exp_press); end
        end
    endtask

    task automatic test_release_all();
        logic [NK-1:0] exp_level, exp_rel;
        KEY = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            exp_level = (c >= 6) ? 4'b0000 : 4'b1111;
            exp_rel   = (c == 7) ? 4'b1111 : 4'b0000;
            n_checks++;
            if (key_level !== exp_level) begin n_fail++; $display("FAIL release_level c=%0d: got %b expected %b", c, key_level, exp_level); end
            n_checks++;
            if (key_release !== exp_rel) begin n_fail++; $display("FAIL release_pulse c=%0d: got %b expected %b", c, key_release, exp_rel); end
        end
        pulse_frame();
        n_checks++;
        if (key_frame_press !== 4'b1111) begin n_fail++; $display("FAIL flush_snapshot: got %b expected 1111", key_frame_press); end
        step(3);
        pulse_frame();
        n_checks++;
        if (key_frame_press !== 4'b0000) begin n_fail++; $display("FAIL empty_frame: got %b expected 0000", key_frame_press); end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 5; r++) begin
            KEY[0] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (c == 3) KEY[0] = 1'b1;
                step(1);
                n_checks++;
                if (key_level[0] !== 1'b0 || key_press[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce r=%0d c=%0d: level %b press %b expected 0 0", r, c, key_level[0], key_press[0]);
                end
            end
        end
        step(4);
        n_checks++;
        if (key_level !== 4'b0000) begin n_fail++; $display("FAIL bounce_settled: got %b expected 0000", key_level); end
    endtask

    task automatic test_frame_capture();
        KEY[1] = 1'b0;
        step(20);
        n_checks++;
        if (key_level !== 4'b0010) begin n_fail++; $display("FAIL capture_level: got %b expected 0010", key_level); end
        n_checks++;
        if (key_frame_press !== 4'b0000) begin n_fail++; $display("FAIL capture_before_frame: got %b expected 0000", key_frame_press); end
        pulse_frame();
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (key_frame_press !== 4'b0010) begin n_fail++; $display("FAIL capture_hold c=%0d: got %b expected 0010", c, key_frame_press); end
            step(1);
        end
        pulse_frame();
        n_checks++;
        if (key_frame_press !== 4'b0000) begin n_fail++; $display("FAIL capture_next_frame: got %b expected 0000", key_frame_press); end
    endtask

    task automatic test_press_with_frame();
        KEY[2] = 1'b0;
        step(7);
        n_checks++;
        if (key_press !== 4'b0100) begin n_fail++; $display("FAIL coinc_press: got %b expected 0100", key_press); end
        pulse_frame();
        n_checks++;
        if (key_frame_press !== 4'b0100) begin n_fail++; $display("FAIL coinc_snapshot: got %b expected 0100", key_frame_press); end
        step(5);
        pulse_frame();
        n_checks++;
        if (key_frame_press !== 4'b0000) begin n_fail++; $display("FAIL coinc_not_carried: got %b expected 0000", key_frame_press); end
    endtask

    task automatic test_double_press();
        int presses, releases;
        presses = 0; releases = 0;
        for (int p = 0; p < 2; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                KEY[3] = (ph == 1);
                for (int c = 0; c < 8; c++) begin
                    step(1);
                    presses  += int'(key_press[3]);
                    releases += int'(key_release[3]);
                end
            end
        end
        for (int c = 0; c < 10; c++) begin
            step(1);
            presses  += int'(key_press[3]);
            releases += int'(key_release[3]);
        end
        n_checks++;
        if (presses != 2) begin n_fail++; $display("FAIL double_press_count: got %0d expected 2", presses); end
        n_checks++;
        if (releases != 2) begin n_fail++; $display("FAIL double_release_count: got %0d expected 2", releases); end
        n_checks++;
        if (key_frame_press !== 4'b0000) begin n_fail++; $display("FAIL double_before_frame: got %b expected 0000", key_frame_press); end
        pulse_frame();
        n_checks++;
        if (key_frame_press !== 4'b1000) begin n_fail++; $display("FAIL double_snapshot: got %b expected 1000", key_frame_press); end
        step(3);
        pulse_frame();
        n_checks++;
        if (key_frame_press !== 4'b0000) begin n_fail++; $display("FAIL double_next_frame: got %b expected 0000", key_frame_press); end
    endtask

    task automatic test_multi_release();
        logic [NK-1:0] exp_rel;
        KEY = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            step(1);
            exp_rel = (c == 7) ? 4'b0110 : 4'b0000;
            n_checks++;
            if (key_release !== exp_rel) begin n_fail++; $display("FAIL multi_release c=%0d: got %b expected %b", c, key_release, exp_rel); end
        end
        n_checks++;
        if (key_level !== 4'b0000) begin n_fail++; $display("FAIL multi_release_level: got %b expected 0000", key_level); end
        pulse_frame();
        n_checks++;
        if (key_frame_press !== 4'b0000) begin n_fail++; $display("FAIL release_not_press: got %b expected 0000", key_frame_press); end
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        logic exp_bit;
        KEY[0] = 1'b0;
        step(10);
        for (int k = 1; k <= 45; k++) begin
            pulse_frame();
            exp_bit = (k == 1) || (k == 30) || (k == 36) || (k == 42);
            n_checks++;
            if (key_frame_press[0] !== exp_bit) begin n_fail++; $display("FAIL repeat k=%0d: got %b expected %b", k, key_frame_press[0], exp_bit); end
            step(2);
        end
        KEY[0] = 1'b1;
        step(10);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_release_all();
        test_bounce();
        test_frame_capture();
        test_press_with_frame();
        test_double_press();
        test_multi_release();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
